dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 25 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: core request/response structs and FSM states.
package dmem_ctrl_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_e;

  // Byte write-enable for a store: one lane for byte stores, all four for word stores.
  function automatic logic [3:0] byte_mask(input logic byte_not_word, input logic [1:0] lane);
    return byte_not_word ? 4'(4'b0001 << lane) : 4'hF;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port RAM, 2^addr_width_p x 32, per-byte write enable, read-first.
module dmem_array #(
  parameter int unsigned addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic [3:0]              we_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  logic [31:0] mem_q [2**addr_width_p];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one request at a time, waits latency_p cycles,
// performs the array access and holds the response until the core consumes it.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    mem_o
);

  localparam int unsigned aw_lp = addr_width_p + 2;

  dmem_state_e      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [aw_lp-1:0] addr_q;
  logic             wen_q, bnw_q;
  logic [31:0]      wdata_q;

  logic             accept, access;
  logic [aw_lp-1:0] acc_addr;
  logic             acc_wen, acc_bnw;
  logic [31:0]      acc_wdata;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata, ram_rdata;
  logic [7:0]       rd_lane;
  logic             unused_addr;

  assign unused_addr = ^addr_i[31:aw_lp];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_i.valid) begin
          accept = 1'b1;
          cnt_d  = 4'(latency_p);
          if (latency_p == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (mem_i.yumi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr_i[aw_lp-1:0];
        wen_q   <= mem_i.wen;
        bnw_q   <= mem_i.byte_not_word;
        wdata_q <= mem_i.write_data;
      end
    end
  end

  // Zero-latency accesses hit the array on the accept edge, so use the live request.
  assign acc_addr  = accept ? addr_i[aw_lp-1:0]    : addr_q;
  assign acc_wen   = accept ? mem_i.wen            : wen_q;
  assign acc_bnw   = accept ? mem_i.byte_not_word  : bnw_q;
  assign acc_wdata = accept ? mem_i.write_data     : wdata_q;

  assign ram_en    = access & reset;
  assign ram_we    = acc_wen ? byte_mask(acc_bnw, acc_addr[1:0]) : '0;
  assign ram_wdata = acc_bnw ? {4{acc_wdata[7:0]}} : acc_wdata;

  dmem_array #(
    .addr_width_p(addr_width_p)
  ) u_array (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (acc_addr[aw_lp-1:2]),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign rd_lane = ram_rdata[{addr_q[1:0], 3'b000} +: 8];

  always_comb begin
    mem_o      = '0;
    mem_o.yumi = (state_q == IDLE) & mem_i.valid & reset;
    if (state_q == RESP) begin
      mem_o.valid = 1'b1;
      if (!wen_q) mem_o.read_data = bnw_q ? {24'h0, rd_lane} : ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl at latency 2 and latency 0 against an array-based reference model.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  mem_in_s     req, mi2, mi0;
  mem_out_s    mo2, mo0, obs;
  logic [31:0] addr_r;
  int          sel = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl [2][1024];

  always #5 clk = ~clk;

  assign mi2 = (sel == 0) ? req : '0;
  assign mi0 = (sel == 1) ? req : '0;
  assign obs = (sel == 0) ? mo2 : mo0;

  dmem_ctrl #(.addr_width_p(10), .latency_p(2)) dut (
    .clk(clk), .reset(reset), .mem_i(mi2), .addr_i(addr_r), .mem_o(mo2));

  dmem_ctrl #(.addr_width_p(10), .latency_p(0)) dut0 (
    .clk(clk), .reset(reset), .mem_i(mi0), .addr_i(addr_r), .mem_o(mo0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: word index = (addr/4) mod 1024, lane = addr mod 4.
  task automatic model_access(input logic wen, input logic bnw, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] exp);
    int i;
    int sh;
    i  = int'((a >> 2) % 1024);
    sh = 8 * int'(a % 4);
    exp = 32'h0;
    if (wen) begin
      if (bnw) mdl[sel][i] = (mdl[sel][i] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      else     mdl[sel][i] = d;
    end else begin
      exp = bnw ? ((mdl[sel][i] >> sh) & 32'hFF) : mdl[sel][i];
    end
  endtask

  // One full transaction; valid stays high and junk is driven while the request is in flight.
  task automatic txn(input logic wen, input logic bnw, input logic [31:0] a, input logic [31:0] d,
                     input int hold, output logic [31:0] rd);
    int          lat;
    int          n;
    logic [31:0] exp;
    logic [31:0] held;
    lat = (sel == 0) ? 2 : 0;
    @(negedge clk);
    req.valid = 1'b1; req.wen = wen; req.byte_not_word = bnw;
    req.write_data = d; req.yumi = 1'b0; addr_r = a;
    #1;
    chk("accept_yumi", 32'(obs.yumi), 32'd1);
    chk("idle_valid", 32'(obs.valid), 32'd0);
    model_access(wen, bnw, a, d, exp);
    @(negedge clk);
    req.write_data = $urandom; req.wen = 1'($urandom); req.byte_not_word = 1'($urandom);
    addr_r = $urandom; req.yumi = 1'b1;
    n = 1;
    while (!obs.valid && n < 20) begin
      chk("busy_yumi", 32'(obs.yumi), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(1 + lat));
    req.yumi = (hold == 0);
    #1;
    chk("resp_yumi", 32'(obs.yumi), 32'd0);
    chk("read_data", obs.read_data, exp);
    held = obs.read_data;
    rd   = held;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == hold - 1) req.yumi = 1'b1;
      #1;
      chk("hold_valid", 32'(obs.valid), 32'd1);
      chk("hold_data", obs.read_data, held);
      chk("hold_yumi", 32'(obs.yumi), 32'd0);
    end
    @(negedge clk);
    req.valid = 1'b0; req.yumi = 1'b0;
    #1;
    chk("post_valid", 32'(obs.valid), 32'd0);
    chk("post_data", obs.read_data, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          acc, vld, both, lat;
    req = '0;
    addr_r = '0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_valid", 32'(obs.valid), 32'd0);
      chk("rst_yumi", 32'(obs.yumi), 32'd0);
      chk("rst_data", obs.read_data, 32'h0);
    end
    reset = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 16; i++) txn(1'b1, 1'b0, 32'(i * 4), $urandom, 0, rd);
    end

    sel = 0;
    txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, rd);
    chk("word_load", rd, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h10, 32'h11223344, 0, rd);
    txn(1'b1, 1'b1, 32'h13, 32'h777777A5, 1, rd);
    chk("store_data", rd, 32'h0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 0, rd);
    chk("byte_merge", rd, 32'hA5223344);
    txn(1'b0, 1'b1, 32'h13, 32'h0, 5, rd);
    chk("byte_load", rd, 32'h000000A5);

    sel = 1;
    txn(1'b1, 1'b0, 32'h1000, 32'h1, 0, rd);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 0, rd);
    chk("wrap_load", rd, 32'h1);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int k = 0; k < 40; k++) begin
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        txn(1'($urandom), 1'($urandom), a, $urandom, int'($urandom_range(0, 2)), rd);
      end
    end

    // Valid and yumi held high: one accept and one response per round trip.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      lat = (s == 0) ? 2 : 0;
      acc = 0; vld = 0; both = 0;
      @(negedge clk);
      req.valid = 1'b1; req.wen = 1'b0; req.byte_not_word = 1'b0; req.yumi = 1'b1; addr_r = 32'h10;
      for (int c = 0; c < 20; c++) begin
        #1;
        acc  += int'(obs.yumi);
        vld  += int'(obs.valid);
        both += int'(obs.yumi & obs.valid);
        @(negedge clk);
      end
      req.valid = 1'b0;
      @(negedge clk);
      req.yumi = 1'b0;
      chk("stream_accepts", 32'(acc), 32'(20 / (lat + 2)));
      chk("stream_resps", 32'(vld), 32'(20 / (lat + 2)));
      chk("stream_overlap", 32'(both), 32'd0);
    end

    sel = 0;
    txn(1'b1, 1'b0, 32'h20, 32'h0BADF00D, 0, rd);
    @(negedge clk);
    req.valid = 1'b1; req.wen = 1'b1; req.byte_not_word = 1'b0;
    req.write_data = 32'hCAFE; addr_r = 32'h20;
    #1;
    chk("abort_accept", 32'(obs.yumi), 32'd1);
    @(negedge clk);
    req.valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_valid", 32'(obs.valid), 32'd0);
    chk("abort_data", obs.read_data, 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_idle_valid", 32'(obs.valid), 32'd0);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 0, rd);
    chk("abort_keep", rd, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
